// File: rtl/cam_pkg.sv
// cam_pkg: shared pixel-format, decimation and state encodings for the camera capture path
package cam_pkg;
  localparam logic [1:0] MODE_RGB444 = 2'd0;
  localparam logic [1:0] MODE_RGB565 = 2'd1;
  localparam logic [1:0] MODE_Y      = 2'd2;
  localparam logic [1:0] DEC_1 = 2'd0;
  localparam logic [1:0] DEC_2 = 2'd1;
  localparam logic [1:0] DEC_4 = 2'd2;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack: combinational byte-pair to 12-bit pixel packer
module cam_pixel_pack
  import cam_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [1:0]  mode,
  output logic [11:0] pixel
);
  // reserved mode values fall through to RGB444
  always_comb
    pixel = mode == MODE_RGB565 ? {b0[7:4], b0[2:0], b1[7], b1[4:1]} :
            mode == MODE_Y      ? {3{b0[7:4]}} :
                                  {b0[3:0], b1};
endmodule

// File: rtl/cam_capture_writer.sv
// cam_capture_writer: camera byte stream to frame-buffer writer with decimation and clipping
module cam_capture_writer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 12,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cap_en,
  input  logic [1:0]        mode,
  input  logic [1:0]        dec_sel,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              ovf_err,
  output logic              phase_err
);
  // counters saturate one past the window so clipped pixels never alias back in
  localparam int XW = $clog2(H_ACTIVE + 1) < 2 ? 2 : $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1) < 2 ? 2 : $clog2(V_ACTIVE + 1);

  state_t            state, state_nx;
  logic              vs_d, href_d, phase;
  logic [7:0]        b0;
  logic [1:0]        mode_r, dec_r, dmask;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  pixel;
  logic              fb, cap, start, pix_ev, line_end, in_win, dec_ok, wr_ok;

  assign fb       = cam_vsync & ~vs_d;
  assign cap      = state == CAPTURE;
  assign busy     = cap;
  assign start    = fb & (state_nx == CAPTURE);
  assign pix_ev   = cap & cam_href & ~fb & phase;
  assign line_end = cap & ~cam_href & href_d & ~fb;
  assign dmask    = dec_r == DEC_1 ? 2'b00 : dec_r == DEC_2 ? 2'b01 : 2'b11;
  assign in_win   = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign dec_ok   = ((x[1:0] | y[1:0]) & dmask) == 2'b00;
  assign wr_ok    = pix_ev & in_win & dec_ok;

  cam_pixel_pack u_pack (
    .b0   (b0),
    .b1   (cam_data),
    .mode (mode_r),
    .pixel(pixel)
  );

  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;

  // next state; a dropped cap_en in WAIT wins over a coincident frame boundary
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cap_en ? WAIT : IDLE;
      WAIT:    state_nx = !cap_en ? IDLE : fb ? CAPTURE : WAIT;
      CAPTURE: state_nx = (fb & ~cap_en) ? IDLE : CAPTURE;
      default: state_nx = IDLE;
    endcase
  end

  // byte pairing, window counters, write port and status flags
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vs_d       <= 1'b0;
      href_d     <= 1'b0;
      phase      <= 1'b0;
      b0         <= '0;
      mode_r     <= MODE_RGB444;
      dec_r      <= DEC_1;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      ovf_err    <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      vs_d       <= cam_vsync;
      href_d     <= cam_href;
      wr_en      <= wr_ok;
      frame_done <= cap & fb;
      ovf_err    <= (pix_ev & ~in_win) | (ovf_err & ~err_clr);
      phase_err  <= (line_end & phase) | (phase_err & ~err_clr);
      if (cap & fb) frame_cnt <= frame_cnt + 1'b1;
      if (wr_ok) begin
        wr_addr <= addr;
        wr_data <= pixel;
        addr    <= addr + 1'b1;
      end
      if (start) begin
        mode_r <= mode == 2'd3 ? MODE_RGB444 : mode;
        dec_r  <= dec_sel == 2'd3 ? DEC_4 : dec_sel;
        x      <= '0;
        y      <= '0;
        phase  <= 1'b0;
        addr   <= '0;
      end else if (cap & cam_href & ~fb) begin
        phase <= ~phase;
        if (!phase) b0 <= cam_data;
        else if (x < XW'(H_ACTIVE)) x <= x + 1'b1;
      end else if (line_end) begin
        x     <= '0;
        phase <= 1'b0;
        if (x != '0 && y < YW'(V_ACTIVE)) y <= y + 1'b1;
      end
    end
endmodule

// File: tb/tb_cam_capture_writer.sv
// tb_cam_capture_writer: directed checks of capture, packing, decimation, clipping and errors
module tb_cam_capture_writer;
  localparam int H = 8, V = 4, AW = 5, FW = 2;

  logic          clk = 1'b0, rstn = 1'b0, cap_en = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0, err_clr = 1'b0;
  logic [1:0]    mode = 2'd0, dec_sel = 2'd0;
  logic [7:0]    cam_data = 8'd0;
  logic          wr_en, frame_done, busy, ovf_err, phase_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [FW-1:0] frame_cnt;

  int n_cmp = 0, n_bad = 0, nw = 0, nfd = 0;
  logic [AW-1:0] wa[512];
  logic [11:0]   wd[512];

  always #5 clk = ~clk;

  cam_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(12), .FCNT_W(FW)) dut (
    .clk(clk), .rstn(rstn), .cap_en(cap_en), .mode(mode), .dec_sel(dec_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy), .ovf_err(ovf_err), .phase_err(phase_err)
  );

  // log every write and frame_done pulse away from the active edge
  always @(negedge clk) begin
    if (wr_en && nw < 512) begin
      wa[nw] = wr_addr;
      wd[nw] = wr_data;
      nw++;
    end
    if (frame_done) nfd++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_fb;
    cam_vsync = 1'b1;
    tick;
    cam_vsync = 1'b0;
    tick;
  endtask

  task automatic send_line(input int n, input logic [7:0] b0v, input logic [7:0] b1v, input bit pat);
    cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      cam_data = (i % 2 == 0) ? b0v : (pat ? {4'(i / 2), 4'h5} : b1v);
      tick;
    end
    cam_href = 1'b0;
    cam_data = 8'd0;
    tick;
    tick;
  endtask

  task automatic chk_run(input string tag, input int base, input int n, input int a0, input logic [11:0] d);
    int bad = 0;
    for (int j = 0; j < n; j++)
      if (wa[base+j] !== AW'(a0 + j) || wd[base+j] !== d) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int base, base2, nfd0, bad;
    tick;
    tick;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_phase", phase_err, 0);
    rstn = 1'b1;
    tick;
    cap_en = 1'b1;
    tick;
    chk("wait_busy", busy, 0);
    send_fb;
    chk("cap_busy", busy, 1);
    chk("first_fb_cnt", frame_cnt, 0);

    base = nw;
    for (int l = 0; l < 4; l++) send_line(16, 8'h0A, 8'hBC, 1'b0);
    chk("full_nwr", nw - base, 32);
    chk_run("full_run", base, 32, 0, 12'hABC);
    chk("full_no_done", nfd, 0);
    send_fb;
    chk("full_done", nfd, 1);
    chk("full_cnt", frame_cnt, 1);

    mode = 2'd1;
    send_fb;
    base = nw;
    send_line(2, 8'hF8, 8'h1F, 1'b0);
    chk("rgb565_nwr", nw - base, 1);
    chk("rgb565_data", wd[base], 12'hF0F);
    chk("rgb565_addr", wa[base], 0);

    mode = 2'd2;
    send_fb;
    base = nw;
    send_line(2, 8'h9C, 8'h00, 1'b0);
    chk("y_data", wd[base], 12'h999);

    mode = 2'd3;
    send_fb;
    chk("cnt_wrap", frame_cnt, 0);
    base = nw;
    send_line(2, 8'h0A, 8'hBC, 1'b0);
    chk("mode3_data", wd[base], 12'hABC);

    mode = 2'd0;
    dec_sel = 2'd1;
    send_fb;
    base = nw;
    for (int l = 0; l < 4; l++) send_line(16, 8'(l), 8'h00, 1'b1);
    chk("dec2_nwr", nw - base, 8);
    bad = 0;
    for (int j = 0; j < 8; j++)
      if (wa[base+j] !== AW'(j) || wd[base+j] !== {4'(2 * (j / 4)), 4'(2 * (j % 4)), 4'h5}) bad++;
    chk("dec2_run", bad, 0);

    dec_sel = 2'd0;
    send_fb;
    base = nw;
    send_line(20, 8'h0A, 8'hBC, 1'b0);
    send_line(20, 8'h0A, 8'hBC, 1'b0);
    chk("ovf_nwr", nw - base, 16);
    chk_run("ovf_run", base, 16, 0, 12'hABC);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_no_phase", phase_err, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("ovf_clr", ovf_err, 0);

    base = nw;
    send_line(15, 8'h0A, 8'hBC, 1'b0);
    chk("odd_nwr", nw - base, 7);
    chk_run("odd_run", base, 7, 16, 12'hABC);
    chk("odd_phase", phase_err, 1);
    chk("odd_no_ovf", ovf_err, 0);
    base2 = nw;
    send_line(16, 8'h0A, 8'hBC, 1'b0);
    chk("repair_nwr", nw - base2, 8);
    chk_run("repair_run", base2, 8, 23, 12'hABC);

    send_fb;
    base = nw;
    send_line(16, 8'h0A, 8'hBC, 1'b0);
    cap_en = 1'b0;
    send_line(16, 8'h0A, 8'hBC, 1'b0);
    chk("drop_busy", busy, 1);
    chk("drop_nwr", nw - base, 16);
    nfd0 = nfd;
    send_fb;
    chk("drop_done", nfd - nfd0, 1);
    chk("drop_idle", busy, 0);
    chk("drop_cnt", frame_cnt, 0);
    base = nw;
    send_line(16, 8'h0A, 8'hBC, 1'b0);
    chk("idle_nwr", nw - base, 0);

    cap_en = 1'b1;
    tick;
    send_fb;
    send_fb;
    chk("pre_rst_cnt", frame_cnt, 1);
    cam_href = 1'b1;
    cam_data = 8'h0A;
    tick;
    cam_data = 8'hBC;
    tick;
    chk("pre_rst_wr", wr_en, 1);
    cam_data = 8'h0A;
    #2 rstn = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_busy", busy, 0);
    cam_href = 1'b0;
    tick;
    rstn = 1'b1;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cam_capture_writer.md
Name: cam_capture_writer

Overview:
- Parametrised successor of the fixed 640x480 RGB444 camera-to-framebuffer write path.
- Takes the OV7670-style byte stream (cam_vsync, cam_href, cam_data) in the camera pixel clock domain.
- Packs byte pairs into PIX_W-bit pixels in a runtime-selectable format, with optional 2x/4x decimation and clipping to the active window.
- Drives the frame-buffer write port (wr_en, wr_addr, wr_data) and reports frame completion and stream errors.

Parameters:
- H_ACTIVE, 640, pixels per line accepted before clipping.
- V_ACTIVE, 480, lines per frame accepted before clipping.
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- PIX_W, 12, output pixel width; fixed at 12 in this generation.
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  camera pixel clock; all inputs are synchronous to it.
- rstn  in  1  asynchronous active-low reset.
- cap_en  in  1  capture enable; sampled only at frame boundaries.
- mode  in  2  pixel format: 0 RGB444, 1 RGB565, 2 Y-only (YUYV), 3 reserved (treated as 0).
- dec_sel  in  2  decimation: 0 none, 1 by 2, 2 by 4, 3 reserved (treated as 2).
- cam_vsync  in  1  camera vertical sync.
- cam_href  in  1  camera line-valid.
- cam_data  in  8  camera byte.
- err_clr  in  1  single-cycle pulse; clears the sticky error flags.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  PIX_W  pixel data.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_cnt  out  FCNT_W  count of completed captured frames; wraps.
- busy  out  1  high while in CAPTURE.
- ovf_err  out  1  sticky; a pixel fell outside the active window.
- phase_err  out  1  sticky; a line ended on an odd byte.

Behaviour:
- Reset: all outputs 0; state IDLE; x, y, byte phase and address counters 0.
- Frame boundary (fb): cam_vsync registered once (vs_d); fb = cam_vsync & ~vs_d.
- State machine:
  - IDLE: on cap_en=1 go to WAIT.
  - WAIT: on fb go to CAPTURE; latch mode and dec_sel; clear x, y, phase, addr. If cap_en drops while in WAIT, go to IDLE.
  - CAPTURE: on fb pulse frame_done and increment frame_cnt. Then, if cap_en=1, stay in CAPTURE and relatch mode, dec_sel and clear counters. If cap_en=0, go to IDLE.
- busy is high only in CAPTURE.
- Byte handling (CAPTURE, cam_href=1, no fb in the same cycle):
  - phase 0: store b0 = cam_data; phase toggles to 1.
  - phase 1: form the pixel from b0 and b1 = cam_data; phase toggles to 0; x increments.
- Pixel packing:
  - RGB444: {b0[3:0], b1[7:0]}.
  - RGB565: {b0[7:4], b0[2:0], b1[7], b1[4:1]}.
  - Y-only: Y = b0; pixel {Y[7:4], Y[7:4], Y[7:4]}.
- Write qualification: a pixel is written only if all of:
  - x < H_ACTIVE and y < V_ACTIVE;
  - x[k-1:0] == 0 and y[k-1:0] == 0, where k = 0, 1 or 2 from dec_sel.
- Write timing: wr_en, wr_addr and wr_data are registered and assert in the cycle after the phase-1 byte. wr_addr is the running addr; addr increments after each write. wr_en is low whenever no pixel is written.
- Out-of-window pixels: not written; ovf_err is set.
- Line end (cam_href falling, detected against the registered href):
  - y increments if x > 0; x returns to 0; phase returns to 0.
  - If phase was 1, set phase_err and drop the partial byte.
- Precedence:
  - fb in the same cycle as a cam_href byte: fb wins and the byte is discarded.
  - err_clr in the same cycle as an error set: set wins.
- Outside CAPTURE: bytes are ignored and wr_en stays 0.
- Reset mid-frame: immediate return to IDLE, no frame_done, frame_cnt cleared.
- frame_cnt wraps from 2^FCNT_W-1 to 0.

Decomposition:
- Package cam_pkg holds:
  - mode constants MODE_RGB444=0, MODE_RGB565=1, MODE_Y=2;
  - decimation constants DEC_1=0, DEC_2=1, DEC_4=2;
  - state encoding IDLE=0, WAIT=1, CAPTURE=2.
- One sub-module, cam_pixel_pack: purely combinational (b0, b1, mode) -> pixel, reused by the VGA test-pattern path.

Test Plan:
- Use H_ACTIVE=8, V_ACTIVE=4, mode 0, dec 0, cap_en=1. Send 2 fb and 4 lines of 16 bytes (b0=0x0A, b1=0xBC) -> exactly 32 writes, addr 0..31, data 0xABC; one frame_done at the second fb; frame_cnt=1.
- mode 1, b0=0xF8, b1=0x1F -> wr_data 0xF0F. mode 2, b0=0x9C -> 0x999.
- dec_sel=1, same 8x4 frame -> 8 writes, addr 0..7, taken only from lines 0 and 2 and even x.
- Lines of 20 bytes (10 pixels) -> 8 writes per line, ovf_err=1. err_clr pulse -> ovf_err=0.
- Line of 15 bytes -> 7 writes and phase_err=1. Next line starts with correct pairing.
- Deassert cap_en mid-frame -> writes continue to fb, then frame_done, then IDLE with busy=0. Assert rstn=0 mid-line -> outputs 0 immediately, frame_cnt=0.
